// File: rtl/mmio_uart_tx_if.sv
// Store/load bus between the CPU data-memory port and the UART transmitter.
interface mmio_uart_tx_if;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, re, addr, wd, input rd);
  modport slave  (input we, re, addr, wd, output rd);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, status/ctrl registers and irq.
// Define IRDA_SIR_EN to add the irda_tx output (IrDA SIR pulse encoder on the same bit stream).
module mmio_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
`ifdef IRDA_SIR_EN
  ,
  output logic           irda_tx
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          enable_reg, overflow_reg, irq_reg;

  logic wr_txdata, wr_status, wr_ctrl;
  logic push, push_ok, pop;
  logic full, empty, busy, baud_done;
  logic [3:0] status_count;
  logic unused_bits;

  assign wr_txdata = bus.we && (bus.addr[3:2] == 2'd0);
  assign wr_status = bus.we && (bus.addr[3:2] == 2'd1);
  assign wr_ctrl   = bus.we && (bus.addr[3:2] == 2'd2);

  assign full      = (count_reg == COUNT_FULL);
  assign empty     = (count_reg == '0);
  assign busy      = (state_reg != IDLE);
  assign baud_done = (baud_reg == BAUD_LAST);
  assign push      = wr_txdata;
  // A push into a full FIFO still lands when the shifter frees a slot on the same edge.
  assign push_ok   = push && (!full || pop);

  assign status_count = 4'(count_reg);
  assign unused_bits  = ^{bus.addr[1:0], bus.wd[31:8]};

  // Next-state logic for the shifter; pops happen only from IDLE or at the end of STOP.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable_reg && !empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        baud_next = baud_reg + BW'(1);
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        baud_next = baud_reg + BW'(1);
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        baud_next = baud_reg + BW'(1);
        if (baud_done) begin
          baud_next = '0;
          bit_next  = '0;
          if (enable_reg && !empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push_ok && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (!push_ok && pop) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  // Storage has no reset; stale entries are never read because count gates every pop.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= bus.wd[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_reg <= bus.wd[0];
      end
      if (push && full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (wr_status && bus.wd[3]) begin
        overflow_reg <= 1'b0;
      end
      irq_reg <= enable_reg && empty && (state_reg == IDLE);
    end
  end

  always_comb begin
    bus.rd = '0;
    if (bus.re) begin
      case (bus.addr[3:2])
        2'd1:    bus.rd = {24'b0, status_count, overflow_reg, busy, empty, full};
        2'd2:    bus.rd = {31'b0, enable_reg};
        default: bus.rd = '0;
      endcase
    end
  end

  // tx is decoded straight from state so an asynchronous reset forces it high at once.
  assign tx  = (state_reg == START) ? 1'b0 :
               (state_reg == DATA)  ? shift_reg[0] : 1'b1;
  assign irq = irq_reg;

`ifdef IRDA_SIR_EN
  localparam logic [BW-1:0] IRDA_WIDTH = BW'(3 * CLK_DIV / 16);

  assign irda_tx = ((state_reg == START) || ((state_reg == DATA) && !shift_reg[0]))
                   && (baud_reg < IRDA_WIDTH);
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized and directed bench for mmio_uart_tx against a frame-level reference model.
module tb_mmio_uart_tx;
  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  localparam logic [3:0] A_TXDATA = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_CTRL   = 4'h8;
  localparam logic [3:0] A_RSVD   = 4'hC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, irq;
`ifdef IRDA_SIR_EN
  logic irda_tx;
`endif

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
`ifdef IRDA_SIR_EN
    ,
    .irda_tx (irda_tx)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: queue of bytes plus the time offset inside the current frame.
  logic [7:0] mq[$];
  bit         m_en = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_active = 1'b0;
  bit         m_irq = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_t = 0;
  bit         mdl_pop;
  logic [7:0] mdl_head;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_en = 1'b0; m_ovf = 1'b0; m_active = 1'b0; m_irq = 1'b0; m_t = 0;
    end else begin
      m_irq   = m_en && (mq.size() == 0) && !m_active;
      mdl_pop = m_en && (mq.size() > 0) && (!m_active || (m_t == FRAME - 1));
      mdl_head = 8'h00;
      if (mdl_pop) mdl_head = mq.pop_front();
      if (bus.we && bus.addr[3:2] == 2'd0) begin
        if (mq.size() < DEPTH) mq.push_back(bus.wd[7:0]);
        else m_ovf = 1'b1;
      end
      if (bus.we && bus.addr[3:2] == 2'd1 && bus.wd[3]) m_ovf = 1'b0;
      if (bus.we && bus.addr[3:2] == 2'd2) m_en = bus.wd[0];
      if (mdl_pop) begin
        m_active = 1'b1; m_t = 0; m_byte = mdl_head;
      end else if (m_active) begin
        if (m_t == FRAME - 1) m_active = 1'b0;
        else m_t = m_t + 1;
      end
    end
  end

  function automatic bit exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic bit exp_irda();
    if (!m_active) return 1'b0;
    return (exp_tx() == 1'b0) && ((m_t % CLK_DIV) < (3 * CLK_DIV / 16));
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!bus.re) return 32'h0;
    case (bus.addr[3:2])
      2'd1:    return {24'b0, 4'(mq.size()), m_ovf, m_active, (mq.size() == 0), (mq.size() == DEPTH)};
      2'd2:    return {31'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    check("rd", bus.rd, exp_rd());
`ifdef IRDA_SIR_EN
    check("irda_tx", {31'b0, irda_tx}, {31'b0, exp_irda()});
`endif
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.we = 1'b1; bus.re = 1'b0; bus.addr = a; bus.wd = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.we = 1'b0; bus.re = 1'b1; bus.addr = a;
    #1;
    check(name, bus.rd, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit         ok;
    logic [9:0] frame_exp;
    int         r;
    bus.we = 1'b0; bus.re = 1'b0; bus.addr = 4'h0; bus.wd = 32'h0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rd_check("reset_status", A_STATUS, 32'h02);
    rd_check("reset_ctrl", A_CTRL, 32'h0);

    // Single frame of 0x55
    wr(A_CTRL, 32'h1);
    wr(A_TXDATA, 32'h55);
    check("tx_before_pop", {31'b0, tx}, 32'h1);
    @(posedge clk); #1;
    check("tx_fall", {31'b0, tx}, 32'h0);
    frame_exp = {1'b1, 8'h55, 1'b0};
    repeat (7) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("frame55_bit%0d", k), {31'b0, tx}, {31'b0, frame_exp[k]});
      repeat (16) @(posedge clk);
    end
    #1;
    check("irq_after_frame", {31'b0, irq}, 32'h1);

    // Overflow with enable low, then back-to-back drain
    do_reset();
    for (int i = 1; i <= 5; i++) wr(A_TXDATA, 32'(i));
    rd_check("full_status", A_STATUS, 32'h49);
    wr(A_CTRL, 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      @(posedge clk); #1;
      if (!m_active && mq.size() == 0) begin ok = 1'b1; break; end
    end
    check("drain_done", {31'b0, ok}, 32'h1);
    rd_check("ovf_still_set", A_STATUS, 32'h0A);
    wr(A_STATUS, 32'h8);
    rd_check("ovf_cleared", A_STATUS, 32'h02);

    // Push into a full FIFO on the exact pop edge
    do_reset();
    for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'h31 + 32'(i));
    wr(A_CTRL, 32'h1);
    wr(A_TXDATA, 32'h35);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (m_active && m_t == FRAME - 1 && mq.size() == DEPTH) begin ok = 1'b1; break; end
    end
    check("found_pop_edge", {31'b0, ok}, 32'h1);
    bus.we = 1'b1; bus.re = 1'b0; bus.addr = A_TXDATA; bus.wd = 32'h77;
    @(posedge clk); #1;
    bus.we = 1'b0;
    rd_check("collide_status", A_STATUS, 32'h45);

    // Disable mid-frame
    do_reset();
    wr(A_CTRL, 32'h1);
    wr(A_TXDATA, 32'hA3);
    wr(A_TXDATA, 32'h11);
    ok = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #1;
      if (m_active && (m_t / CLK_DIV) == 4) begin ok = 1'b1; break; end
    end
    check("reached_bit3", {31'b0, ok}, 32'h1);
    wr(A_CTRL, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #1;
      if (!m_active) begin ok = 1'b1; break; end
    end
    check("frame_completed", {31'b0, ok}, 32'h1);
    repeat (40) @(posedge clk);
    #1;
    check("disabled_tx_idle", {31'b0, tx}, 32'h1);
    rd_check("disabled_status", A_STATUS, 32'h10);

    // Asynchronous reset during a frame
    do_reset();
    wr(A_CTRL, 32'h1);
    wr(A_TXDATA, 32'hFF);
    wr(A_TXDATA, 32'h11);
    wr(A_TXDATA, 32'h22);
    ok = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #1;
      if (m_active && (m_t / CLK_DIV) == 3) begin ok = 1'b1; break; end
    end
    check("reached_data", {31'b0, ok}, 32'h1);
    bus.we = 1'b0; bus.re = 1'b1; bus.addr = A_STATUS;
    #1 reset = 1'b1;
    #1;
    check("async_reset_tx", {31'b0, tx}, 32'h1);
    check("async_reset_status", bus.rd, 32'h02);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    rd_check("post_reset_status", A_STATUS, 32'h02);
    rd_check("post_reset_ctrl", A_CTRL, 32'h0);
    repeat (50) @(posedge clk);
    #1;
    check("post_reset_quiet", {31'b0, tx}, 32'h1);

`ifdef IRDA_SIR_EN
    begin
      int starts[$];
      int widths[$];
      bit prev;
      int w;
      prev = 1'b0; w = 0;
      do_reset();
      wr(A_CTRL, 32'h1);
      wr(A_TXDATA, 32'h00);
      for (int c = 0; c < 200; c++) begin
        @(posedge clk); #1;
        if (irda_tx && !prev) begin starts.push_back(c); w = 1; end
        else if (irda_tx) w++;
        if (!irda_tx && prev) widths.push_back(w);
        prev = irda_tx;
      end
      check("irda_pulses", 32'(starts.size()), 32'd9);
      foreach (widths[i]) check($sformatf("irda_width%0d", i), 32'(widths[i]), 32'd3);
      for (int i = 1; i < starts.size(); i++)
        check($sformatf("irda_spacing%0d", i), 32'(starts[i] - starts[i-1]), 32'd16);
    end
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 99);
      bus.we = 1'b0; bus.re = 1'b0;
      bus.wd = $urandom();
      bus.addr = 4'($urandom_range(0, 3));
      if (r < 10) begin
        bus.we = 1'b1; bus.addr[3:2] = 2'd0;
      end else if (r < 14) begin
        bus.we = 1'b1; bus.addr[3:2] = 2'd2;
        bus.wd[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 17) begin
        bus.we = 1'b1; bus.addr[3:2] = 2'd1;
      end else if (r < 19) begin
        bus.we = 1'b1; bus.addr[3:2] = 2'd3;
      end else if (r < 90) begin
        bus.re = 1'b1; bus.addr = 4'($urandom_range(0, 15));
      end
    end
    @(posedge clk); #1;
    bus.we = 1'b0; bus.re = 1'b0;
    repeat (4) @(posedge clk);
    rd_check("rsvd_read", A_RSVD, 32'h0);
    rd_check("txdata_read", A_TXDATA, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
